// File: rtl/rr_mux_arbiter.sv
// N-channel valid/ready mux: a round-robin or fixed-priority arbiter feeds a one-entry output register.
// Latency: one cycle from input transfer to out_data/out_valid.
// Backpressure: in_ready is low while the held word is stalled (out_valid && !out_ready); drain and load can share an edge.
module rr_mux_arbiter #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  hi_idx;
  logic [CH_W-1:0]  lo_idx;
  logic [CH_W-1:0]  gnt_idx;
  logic             hi_found;
  logic             any_req;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // The output register can take a new word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;
  assign any_req = |in_valid;
  assign xfer    = rst_n && load_en && any_req;

  // Find the lowest requester overall and the lowest requester at or above the pointer.
  // Scanning downwards lets the last hit win, which is the lowest index.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_idx = CH_W'(i);
        if (CH_W'(i) >= ptr) begin
          hi_idx   = CH_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  // Round-robin wraps to the lowest requester when nothing sits at or above the pointer;
  // fixed priority ignores the pointer entirely.
  always_comb begin
    gnt_idx = lo_idx;
    if (!mode && hi_found) begin
      gnt_idx = hi_idx;
    end
  end

  // One-hot accept to the granted channel, gated by register availability and reset.
  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Pick the granted channel's word out of the packed input bus.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register, transfer counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= gnt_idx;
        xfer_cnt  <= xfer_cnt + 1'b1;
        if (!mode) begin
          ptr <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_ch;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int m_vld  = 0;
  int m_data = 0;
  int m_ch   = 0;
  int m_cnt  = 0;
  int m_ptr  = 0;

  rr_mux_arbiter #(.N_CH(N), .WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel granted by the arbitration rules, or -1 when nobody requests.
  function automatic int pick(input logic [N-1:0] v, input logic md, input int p);
    for (int off = 0; off < N; off++) begin
      int k;
      k = md ? off : (p + off) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Apply one cycle of inputs, check the accept, then check the registered outputs.
  task automatic cycle(input logic r, input logic md, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input logic ordy);
    int g;
    int load;
    logic [N-1:0] exp_rdy;
    rst_n = r; mode = md; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    load    = (m_vld == 0) || ordy;
    g       = pick(v, md, m_ptr);
    exp_rdy = '0;
    if (r && load != 0 && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (!r) begin
      m_vld = 0; m_data = 0; m_ch = 0; m_cnt = 0; m_ptr = 0;
    end else if (load != 0 && g >= 0) begin
      m_vld  = 1;
      m_data = d[g*W +: W];
      m_ch   = g;
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      if (!md) m_ptr = (g + 1) % N;
    end else if (m_vld != 0 && ordy) begin
      m_vld = 0;
    end
    #1;
    check("out_valid", out_valid, m_vld);
    check("out_data", out_data, m_data);
    check("out_ch", out_ch, m_ch);
    check("xfer_cnt", xfer_cnt, m_cnt);
    @(negedge clk);
  endtask

  localparam logic [N*W-1:0] SWEEP = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  initial begin
    int guard;
    rst_n = 1'b0; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // reset with all channels requesting
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 4'b1111, SWEEP, 1'b1);
    check("rst_cnt", xfer_cnt, 0);

    // round-robin sweep: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 4'b1111, SWEEP, 1'b1);
      check("sweep_ch", out_ch, i % N);
      check("sweep_data", out_data, 8'hA0 + (i % N));
    end
    check("sweep_cnt", xfer_cnt, 5);

    // fixed priority
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 4'b1010, SWEEP, 1'b1);
      check("fp_ch1", out_ch, 1);
    end
    cycle(1'b1, 1'b1, 4'b1000, SWEEP, 1'b1);
    check("fp_ch3", out_ch, 3);

    // backpressure: hold 0x55, then drain and load in one edge
    cycle(1'b1, 1'b0, 4'b0001, {24'h0, 8'h55}, 1'b1);
    check("bp_load", out_data, 8'h55);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 4'b0001, {24'h0, 8'h77}, 1'b0);
      check("bp_rdy", in_ready, 0);
      check("bp_hold", out_data, 8'h55);
    end
    cycle(1'b1, 1'b0, 4'b0001, {24'h0, 8'h77}, 1'b1);
    check("bp_swap_vld", out_valid, 1);
    check("bp_swap_data", out_data, 8'h77);

    // sparse request on ch2 then drain
    cycle(1'b1, 1'b0, 4'b0000, '0, 1'b1);
    cycle(1'b1, 1'b0, 4'b0100, {8'h0, 8'h3C, 16'h0}, 1'b1);
    check("sp_vld", out_valid, 1);
    check("sp_ch", out_ch, 2);
    cycle(1'b1, 1'b0, 4'b0000, '0, 1'b1);
    check("sp_drain", out_valid, 0);
    check("sp_hold_ch", out_ch, 2);
    cycle(1'b1, 1'b0, 4'b1111, SWEEP, 1'b1);
    check("sp_next_ch3", out_ch, 3);

    // counter wrap: run to 15, then two more
    guard = 0;
    while (m_cnt != 15 && guard < 40) begin
      cycle(1'b1, 1'b0, 4'b1111, SWEEP, 1'b1);
      guard++;
    end
    check("wrap_15", xfer_cnt, 15);
    cycle(1'b1, 1'b0, 4'b1111, SWEEP, 1'b1);
    check("wrap_0", xfer_cnt, 0);
    cycle(1'b1, 1'b0, 4'b1111, SWEEP, 1'b1);
    check("wrap_1", xfer_cnt, 1);

    // reset while holding a word
    cycle(1'b0, 1'b0, 4'b1111, SWEEP, 1'b0);
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_cnt", xfer_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic r;
      r = ($urandom_range(0, 59) != 0);
      cycle(r, 1'($urandom_range(0, 3) == 0), 4'($urandom), {$urandom},
            1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
